// File: rtl/alu_seq16_if.sv
// Bundles the requester handshake and the narrow ALU connection of the
// nibble-serial sequencer. The slave side is the sequencer itself. The master
// side is the environment: the requester plus the 4-bit ALU.
interface alu_seq16_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         start;
    logic [2:0]   op;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         CarryIn;
    logic         busy;
    logic         done;
    logic [W-1:0] Result;
    logic         CarryOut;
    logic [3:0]   ALU_A;
    logic [3:0]   ALU_B;
    logic [3:0]   ALU_Sel;
    logic         ALU_CarryIn;
    logic [3:0]   ALU_Result;
    logic         ALU_CarryOut;

    modport master (
        output start, op, A, B, CarryIn, ALU_Result, ALU_CarryOut,
        input  busy, done, Result, CarryOut, ALU_A, ALU_B, ALU_Sel, ALU_CarryIn
    );

    modport slave (
        input  start, op, A, B, CarryIn, ALU_Result, ALU_CarryOut,
        output busy, done, Result, CarryOut, ALU_A, ALU_B, ALU_Sel, ALU_CarryIn
    );
endinterface

// File: rtl/alu_seq16.sv
// Nibble-serial wide ALU sequencer. It feeds one 4-bit slice per cycle,
// LSB first, into an external combinational 4-bit ALU. The ALU carry/borrow
// is chained from one slice to the next, and the wide result is assembled in
// a register. A request is accepted only in IDLE. The result appears with a
// one-cycle done pulse and is then held until the next accepted request.
module alu_seq16 #(
    parameter int NIBBLES = 4
) (
    input logic        clk,
    input logic        reset,
    alu_seq16_if.slave bus
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = $clog2(NIBBLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_ADDC = 3'b010,
        OP_SUBB = 3'b011,
        OP_AND  = 3'b100,
        OP_OR   = 3'b101,
        OP_XOR  = 3'b110,
        OP_EQ   = 3'b111
    } op_e;

    state_e        state_q;
    op_e           opLat_q;
    logic [W-1:0]  aLat_q;
    logic [W-1:0]  bLat_q;
    logic [IW-1:0] idx_q;
    logic          carry_q;
    logic          eq_q;
    logic          busy_q;
    logic          done_q;
    logic [W-1:0]  result_q;
    logic          carryOut_q;

    logic [IW-1:0] idx_d;
    logic          eq_d;
    logic [W-1:0]  result_d;
    logic          isArith;
    logic          lastNibble;
    logic          startIsArith;

    logic [3:0]    aluA;
    logic [3:0]    aluB;
    logic [3:0]    aluSel;
    logic          aluCin;

    // Arithmetic ops are the four codes with op[2] clear. Only these use the
    // carry chain and report a carry/borrow out.
    assign isArith      = ~opLat_q[2];
    assign startIsArith = (bus.op == OP_ADDC) || (bus.op == OP_SUBB);
    assign lastNibble   = (idx_q == IW'(NIBBLES - 1));
    assign idx_d        = idx_q + IW'(1);
    assign eq_d         = eq_q & bus.ALU_Result[0];

    // Next wide result: the current slice replaced by this cycle's ALU output.
    always_comb begin
        result_d = result_q;
        result_d[4*idx_q +: 4] = bus.ALU_Result;
    end

    // ALU drive: the current operand slices in RUN. The ALU is parked at zero
    // in every other state so that it sees a quiet, known input.
    always_comb begin
        aluA   = 4'b0000;
        aluB   = 4'b0000;
        aluSel = 4'b0000;
        aluCin = 1'b0;
        if (state_q == RUN) begin
            aluA   = aLat_q[4*idx_q +: 4];
            aluB   = bLat_q[4*idx_q +: 4];
            aluCin = isArith ? carry_q : 1'b0;
            case (opLat_q)
                OP_ADD:  aluSel = (idx_q == '0) ? 4'b0000 : 4'b0010;
                OP_SUB:  aluSel = (idx_q == '0) ? 4'b0001 : 4'b0011;
                OP_ADDC: aluSel = 4'b0010;
                OP_SUBB: aluSel = 4'b0011;
                OP_AND:  aluSel = 4'b0100;
                OP_OR:   aluSel = 4'b0101;
                OP_XOR:  aluSel = 4'b0110;
                OP_EQ:   aluSel = 4'b1100;
                default: aluSel = 4'b0000;
            endcase
        end
    end

    // Control FSM. It latches the request, walks the slices, and produces the
    // done pulse together with the final result and carry.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            opLat_q    <= OP_ADD;
            aLat_q     <= '0;
            bLat_q     <= '0;
            idx_q      <= '0;
            carry_q    <= 1'b0;
            eq_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
            carryOut_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        opLat_q  <= op_e'(bus.op);
                        aLat_q   <= bus.A;
                        bLat_q   <= bus.B;
                        idx_q    <= '0;
                        result_q <= '0;
                        carry_q  <= startIsArith ? bus.CarryIn : 1'b0;
                        eq_q     <= 1'b1;
                        busy_q   <= 1'b1;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    carry_q <= bus.ALU_CarryOut;
                    eq_q    <= eq_d;
                    idx_q   <= idx_d;
                    if (lastNibble) begin
                        result_q   <= (opLat_q == OP_EQ) ? W'(eq_d) : result_d;
                        carryOut_q <= isArith ? bus.ALU_CarryOut : 1'b0;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        idx_q      <= '0;
                        state_q    <= DONE;
                    end else begin
                        result_q <= result_d;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.Result      = result_q;
    assign bus.CarryOut    = carryOut_q;
    assign bus.ALU_A       = aluA;
    assign bus.ALU_B       = aluB;
    assign bus.ALU_Sel     = aluSel;
    assign bus.ALU_CarryIn = aluCin;
endmodule

// File: tb/tb_alu_seq16.sv
// Bench for alu_seq16. It models the external 4-bit ALU and runs a table of
// hand-computed wide operations. It then runs the protocol and reset-abort
// corner cases as hand-written sequences.
module tb_alu_seq16;
    logic clk;
    logic reset;
    int   total;
    int   bad;

    alu_seq16_if #(.NIBBLES(4)) bus ();

    alu_seq16 #(.NIBBLES(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [4:0] aluT;

    // Reference model of the team's 4-bit ALU. Bit 4 carries the carry out, or
    // the borrow for the subtract selects. Compare puts A==B in bit 0.
    always_comb begin
        aluT = 5'd0;
        case (bus.ALU_Sel)
            4'b0000: aluT = {1'b0, bus.ALU_A} + {1'b0, bus.ALU_B};
            4'b0010: aluT = {1'b0, bus.ALU_A} + {1'b0, bus.ALU_B} + {4'b0, bus.ALU_CarryIn};
            4'b0001: aluT = {1'b0, bus.ALU_A} - {1'b0, bus.ALU_B};
            4'b0011: aluT = {1'b0, bus.ALU_A} - {1'b0, bus.ALU_B} - {4'b0, bus.ALU_CarryIn};
            4'b0100: aluT = {1'b0, bus.ALU_A & bus.ALU_B};
            4'b0101: aluT = {1'b0, bus.ALU_A | bus.ALU_B};
            4'b0110: aluT = {1'b0, bus.ALU_A ^ bus.ALU_B};
            4'b1100: aluT = {4'b0, bus.ALU_A == bus.ALU_B};
            default: aluT = 5'd0;
        endcase
    end

    assign bus.ALU_Result   = aluT[3:0];
    assign bus.ALU_CarryOut = aluT[4];

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] expRes;
        logic        expCo;
        logic [15:0] expSel;
    } vec_t;

    vec_t vecs[13];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Issues one request and follows it to its done pulse. The operand inputs
    // are scrambled right after acceptance to show that the latched copies are
    // the ones used. A latency of 0 means done never arrived.
    task automatic applyStimulus(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                                 input logic cin, output int latency, output int busyCnt,
                                 output logic [15:0] selSeq, output logic [15:0] res, output logic co);
        @(negedge clk);
        bus.op      = op;
        bus.A       = a;
        bus.B       = b;
        bus.CarryIn = cin;
        bus.start   = 1'b1;
        @(posedge clk);
        latency = 0;
        busyCnt = 0;
        selSeq  = 16'h0;
        res     = 16'h0;
        co      = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 1) begin
                bus.start   = 1'b0;
                bus.A       = ~a;
                bus.B       = ~b;
                bus.CarryIn = ~cin;
                bus.op      = ~op;
            end
            if (bus.busy) begin
                busyCnt++;
                selSeq = {selSeq[11:0], bus.ALU_Sel};
            end
            if (bus.done) begin
                latency = i;
                res     = bus.Result;
                co      = bus.CarryOut;
                break;
            end
        end
    endtask

    initial begin
        int          latency;
        int          busyCnt;
        int          doneCnt;
        logic [15:0] selSeq;
        logic [15:0] res;
        logic        co;

        total = 0;
        bad   = 0;

        vecs[0]  = '{"add_wrap",  3'b000, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 16'h0222};
        vecs[1]  = '{"sub_1000",  3'b001, 16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0, 16'h1333};
        vecs[2]  = '{"sub_under", 3'b001, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 16'h1333};
        vecs[3]  = '{"addc",      3'b010, 16'h00FF, 16'h0000, 1'b1, 16'h0100, 1'b0, 16'h2222};
        vecs[4]  = '{"subb",      3'b011, 16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1, 16'h3333};
        vecs[5]  = '{"xor",       3'b110, 16'hA5A5, 16'hFFFF, 1'b0, 16'h5A5A, 1'b0, 16'h6666};
        vecs[6]  = '{"eq_same",   3'b111, 16'h1234, 16'h1234, 1'b0, 16'h0001, 1'b0, 16'hCCCC};
        vecs[7]  = '{"eq_diff",   3'b111, 16'h1234, 16'h1235, 1'b0, 16'h0000, 1'b0, 16'hCCCC};
        vecs[8]  = '{"and",       3'b100, 16'hF0F0, 16'h3C3C, 1'b1, 16'h3030, 1'b0, 16'h4444};
        vecs[9]  = '{"or",        3'b101, 16'h1200, 16'h0034, 1'b1, 16'h1234, 1'b0, 16'h5555};
        vecs[10] = '{"add_plain", 3'b000, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 16'h0222};
        vecs[11] = '{"add_cin",   3'b000, 16'h0001, 16'h0001, 1'b1, 16'h0002, 1'b0, 16'h0222};
        vecs[12] = '{"sub_cin",   3'b001, 16'h0005, 16'h0003, 1'b1, 16'h0002, 1'b0, 16'h1333};

        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.op      = 3'b000;
        bus.A       = 16'h0;
        bus.B       = 16'h0;
        bus.CarryIn = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_busy", 32'(bus.busy), 32'h0);
        checkOutput("rst_done", 32'(bus.done), 32'h0);
        checkOutput("rst_result", 32'(bus.Result), 32'h0);
        checkOutput("rst_carry", 32'(bus.CarryOut), 32'h0);
        checkOutput("rst_alusel", 32'(bus.ALU_Sel), 32'h0);
        reset = 1'b0;

        // Table-driven operations
        for (int v = 0; v < 13; v++) begin
            applyStimulus(vecs[v].op, vecs[v].a, vecs[v].b, vecs[v].cin, latency, busyCnt, selSeq, res, co);
            checkOutput({vecs[v].name, "_result"}, 32'(res), 32'(vecs[v].expRes));
            checkOutput({vecs[v].name, "_carry"}, 32'(co), 32'(vecs[v].expCo));
            checkOutput({vecs[v].name, "_latency"}, 32'(latency), 32'd5);
            checkOutput({vecs[v].name, "_busycnt"}, 32'(busyCnt), 32'd4);
            checkOutput({vecs[v].name, "_selseq"}, 32'(selSeq), 32'(vecs[v].expSel));
            @(negedge clk);
            checkOutput({vecs[v].name, "_done_low"}, 32'(bus.done), 32'h0);
            checkOutput({vecs[v].name, "_held"}, 32'(bus.Result), 32'(vecs[v].expRes));
        end

        // Start pulses during RUN and DONE must all be ignored
        @(negedge clk);
        bus.op    = 3'b000;
        bus.A     = 16'h1234;
        bus.B     = 16'h4321;
        bus.start = 1'b1;
        @(posedge clk);
        doneCnt = 0;
        res     = 16'h0;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            if (bus.done) begin
                doneCnt++;
                res = bus.Result;
            end
            bus.start   = 1'b1;
            bus.op      = 3'(i + 1);
            bus.A       = 16'hFFFF;
            bus.B       = 16'(i * 16'h1111);
            bus.CarryIn = 1'b1;
        end
        @(negedge clk);
        bus.start = 1'b0;
        checkOutput("proto_busy_after", 32'(bus.busy), 32'h0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.done) doneCnt++;
        end
        checkOutput("proto_done_count", 32'(doneCnt), 32'd1);
        checkOutput("proto_result", 32'(res), 32'h5555);
        checkOutput("proto_final", 32'(bus.Result), 32'h5555);

        // Reset in the second RUN cycle aborts without a done pulse
        @(negedge clk);
        bus.op    = 3'b000;
        bus.A     = 16'hFFFF;
        bus.B     = 16'h0001;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("abort_busy", 32'(bus.busy), 32'h0);
        checkOutput("abort_result", 32'(bus.Result), 32'h0);
        checkOutput("abort_alusel", 32'(bus.ALU_Sel), 32'h0);
        doneCnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.done) doneCnt++;
        end
        checkOutput("abort_no_done", 32'(doneCnt), 32'd0);
        applyStimulus(3'b000, 16'h0001, 16'h0001, 1'b0, latency, busyCnt, selSeq, res, co);
        checkOutput("after_abort_result", 32'(res), 32'h0002);
        checkOutput("after_abort_latency", 32'(latency), 32'd5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_seq16.md
Name: alu_seq16

Overview:
- Multi-cycle sequencer that runs NIBBLES×4-bit operations (16-bit by default) on the team's existing 4-bit combinational ALU.
- It slices the operands into nibbles and drives one nibble per cycle into the ALU select/operand/carry ports, LSB nibble first.
- It chains ALU carry/borrow out to the next nibble's carry in, and assembles the wide result.
- Sits between a requester using a start/done handshake and a single ALU instance.

Parameters:
- NIBBLES, 4, number of 4-bit slices; operand/result width W = 4*NIBBLES (NIBBLES >= 2).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- op  input  3  operation code, latched with start.
- A  input  W  operand A, latched with start.
- B  input  W  operand B, latched with start.
- CarryIn  input  1  carry/borrow in for ADDC/SUBB, latched with start.
- busy  output  1  high from the cycle after start acceptance until the cycle before done.
- done  output  1  one-cycle pulse; Result/CarryOut valid in that cycle and held afterwards.
- Result  output  W  wide result.
- CarryOut  output  1  final carry/borrow out (0 for logic/EQ ops).
- ALU_A  output  4  nibble to ALU operand A.
- ALU_B  output  4  nibble to ALU operand B.
- ALU_Sel  output  4  ALU select.
- ALU_CarryIn  output  1  ALU carry in.
- ALU_Result  input  4  ALU result, combinational from ALU_* outputs.
- ALU_CarryOut  input  1  ALU carry/borrow out, combinational.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset: state=IDLE; busy=0, done=0, Result=0, CarryOut=0, nibble index=0, internal carry=0, eq flag=1. Reset mid-operation aborts immediately and produces no done.
- ALU drive in IDLE and DONE: ALU_A=0, ALU_B=0, ALU_Sel=4'b0000, ALU_CarryIn=0.
- States: IDLE, RUN, DONE.
  - IDLE: if start, latch A, B, op, CarryIn; idx=0; clear Result; carry=CarryIn for ADDC/SUBB, else 0; eq=1; go to RUN. busy rises next cycle.
  - RUN: ALU_A=A[4*idx+:4], ALU_B=B[4*idx+:4]. At each clock edge: Result[4*idx+:4] <= ALU_Result; carry <= ALU_CarryOut; eq <= eq & ALU_Result[0]; idx++. After the idx==NIBBLES-1 edge, go to DONE.
  - DONE: done=1, busy=0; CarryOut=carry for arithmetic ops, else 0. For EQ: Result={W-1 zeros, eq}. Next cycle go to IDLE.
- Latency: start sampled at edge T → done high in cycle T+NIBBLES+1. Throughput is one op per NIBBLES+2 cycles. A start asserted in the DONE cycle is ignored; back-to-back starts need one IDLE cycle.
- Op map, giving ALU_Sel for nibble 0 / nibbles 1..N-1:
  - 000 ADD: 0000 / 0010 (chained).
  - 001 SUB: 0001 / 0011 (borrow chained).
  - 010 ADDC: 0010 / 0010, nibble 0 carry=CarryIn.
  - 011 SUBB: 0011 / 0011, nibble 0 borrow=CarryIn.
  - 100 AND: 0100.
  - 101 OR: 0101.
  - 110 XOR: 0110.
  - 111 EQ: 1100, per-nibble compare.
- ALU_CarryIn in RUN = internal carry for arithmetic ops, 0 otherwise.
- Borrow convention: ALU_CarryOut=1 on a nibble subtract means borrow. A final CarryOut=1 on SUB/SUBB means A < B (+borrow-in) unsigned.
- start while busy or in DONE: ignored, with no effect on latched operands.
- Operand inputs may change freely after acceptance; only the latched copies are used.
- Result holds its last value in IDLE until the next accepted start clears it.

Test Plan:
- ADD A=16'hFFFF B=16'h0001 → Result=16'h0000, CarryOut=1, done exactly 5 cycles after the start edge; busy high for 4 cycles; ALU_Sel sequence 0000,0010,0010,0010.
- SUB A=16'h1000 B=16'h0001 → Result=16'h0FFF, CarryOut=0. SUB A=16'h0000 B=16'h0001 → Result=16'hFFFF, CarryOut=1.
- ADDC A=16'h00FF B=16'h0000 CarryIn=1 → Result=16'h0100, CarryOut=0. SUBB A=16'h0005 B=16'h0005 CarryIn=1 → Result=16'hFFFF, CarryOut=1.
- Logic and EQ:
  - XOR A=16'hA5A5 B=16'hFFFF → 16'h5A5A, CarryOut=0.
  - EQ 16'h1234 vs 16'h1234 → Result=1.
  - EQ 16'h1234 vs 16'h1235 → Result=0.
- Protocol: pulse start with a new op on every cycle during RUN and DONE → only the first op executes; its result is unaffected; exactly one done pulse.
- Reset mid-op: assert reset in the 2nd RUN cycle → next cycle IDLE, busy=0, Result=0, no done. A subsequent ADD 16'h0001+16'h0001 → 16'h0002.
